// File: rtl/noc_input_buffer_bank_if.sv
// rtl/noc_input_buffer_bank_if.sv - link/consumer bundle for the per-port NoC input buffer bank
// Channel p of each packed bus occupies [p*W +: W].
interface noc_input_buffer_bank_if #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16,
    parameter int DEPTH     = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_PORTS-1:0]        valid_i;
    logic [NUM_PORTS*FLIT_W-1:0] data_i;
    logic [NUM_PORTS-1:0]        pop_req_i;
    logic [NUM_PORTS*FLIT_W-1:0] q_o;
    logic [NUM_PORTS-1:0]        en_o;
    logic [NUM_PORTS-1:0]        full_o;
    logic [NUM_PORTS*CNT_W-1:0]  count_o;
    logic [NUM_PORTS-1:0]        credit_o;
    logic [NUM_PORTS-1:0]        ovf_o;

    modport master (
        output valid_i, data_i, pop_req_i,
        input  q_o, en_o, full_o, count_o, credit_o, ovf_o
    );

    modport slave (
        input  valid_i, data_i, pop_req_i,
        output q_o, en_o, full_o, count_o, credit_o, ovf_o
    );
endinterface

// File: rtl/noc_input_buffer_bank.sv
// rtl/noc_input_buffer_bank.sv - per-port FWFT input FIFOs with credit/overflow reporting
// Optional empty-FIFO bypass is compiled in with NOC_BUF_BYPASS_EN.
module noc_input_buffer_bank #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16,
    parameter int DEPTH     = 4
) (
    input logic                    clk,
    input logic                    rst,
    noc_input_buffer_bank_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
        logic [FLIT_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;
        logic              credit;
        logic              ovf;

        logic              valid;
        logic              pop_req;
        logic [FLIT_W-1:0] din;
        logic              stored;
        logic              full;
        logic              bypass;
        logic              en;
        logic [FLIT_W-1:0] head;
        logic              pop_acc;
        logic              push_acc;
        logic              wr;
        logic              rd;
        logic              drop;

        assign valid   = bus.valid_i[p];
        assign pop_req = bus.pop_req_i[p];
        assign din     = bus.data_i[p*FLIT_W +: FLIT_W];

        assign stored  = (cnt != '0);
        assign full    = (cnt == CNT_W'(DEPTH));

`ifdef NOC_BUF_BYPASS_EN
        // An arriving flit on an empty channel is presented at once.
        assign bypass = valid & ~stored;

        always_comb begin
            head = '0;
            if (stored) begin
                head = mem[rd_ptr];
            end else if (bypass) begin
                head = din;
            end
        end
`else
        assign bypass = 1'b0;

        always_comb begin
            head = '0;
            if (stored) begin
                head = mem[rd_ptr];
            end
        end
`endif

        assign en       = stored | bypass;
        assign pop_acc  = pop_req & en;
        assign push_acc = valid & (~full | pop_acc);
        assign drop     = valid & full & ~pop_acc;
        // A bypassed flit that is popped in the same cycle never touches storage.
        assign wr       = push_acc & ~(bypass & pop_req);
        assign rd       = pop_acc & stored;

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                credit <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                if (wr) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({wr, rd})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
                credit <= pop_acc;
                if (drop) begin
                    ovf <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (wr && !rst) begin
                mem[wr_ptr] <= din;
            end
        end

        assign bus.q_o[p*FLIT_W +: FLIT_W]   = head;
        assign bus.en_o[p]                   = en;
        assign bus.full_o[p]                 = full;
        assign bus.count_o[p*CNT_W +: CNT_W] = cnt;
        assign bus.credit_o[p]               = credit;
        assign bus.ovf_o[p]                  = ovf;
    end
endmodule

// File: tb/tb_noc_input_buffer_bank.sv
// tb/tb_noc_input_buffer_bank.sv - scoreboard bench for noc_input_buffer_bank (honours NOC_BUF_BYPASS_EN)
module tb_noc_input_buffer_bank;
    localparam int NP = 5;
    localparam int FW = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_input_buffer_bank_if #(.NUM_PORTS(NP), .FLIT_W(FW), .DEPTH(D)) bus ();

    noc_input_buffer_bank #(.NUM_PORTS(NP), .FLIT_W(FW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [FW-1:0] exp_q [NP][$];
    int credit_seen [NP];

    function automatic logic [FW-1:0] q_of(input int p);
        return bus.q_o[p*FW +: FW];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int p);
        return bus.count_o[p*CW +: CW];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i   = '0;
        bus.data_i    = '0;
        bus.pop_req_i = '0;
    endtask

    task automatic drive(input int p, input logic v, input logic [FW-1:0] d, input logic pr);
        bus.valid_i[p]         = v;
        bus.data_i[p*FW +: FW] = d;
        bus.pop_req_i[p]       = pr;
    endtask

    task automatic expect_pop(input int p, input logic [FW-1:0] d);
        exp_q[p].push_back(d);
    endtask

    // Monitor: every accepted pop must match the oldest expected flit of that port.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int p = 0; p < NP; p++) begin
                if (bus.pop_req_i[p] && bus.en_o[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pop_p%0d: got pop of %0h expected no pop", p, q_of(p));
                    end else begin
                        check($sformatf("pop_data_p%0d", p), 32'(q_of(p)), 32'(exp_q[p].pop_front()));
                    end
                end
                if (bus.credit_o[p]) credit_seen[p]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_cnt [10] = '{2, 2, 1, 2, 2, 1, 2, 2, 1, 2};
        logic [FW-1:0] nxt_push;
        logic [FW-1:0] nxt_pop;
        logic ph;
        logic pp;

        for (int p = 0; p < NP; p++) credit_seen[p] = 0;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and pops on empty channels
        check("rst_en", bus.en_o, 0);
        check("rst_full", bus.full_o, 0);
        check("rst_q", bus.q_o, 0);
        check("rst_count", bus.count_o, 0);
        check("rst_credit", bus.credit_o, 0);
        check("rst_ovf", bus.ovf_o, 0);
        bus.pop_req_i = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("empty_pop_credit", bus.credit_o, 0);
            check("empty_pop_count", bus.count_o, 0);
        end
        idle();
        step();
        check("empty_pop_credit_tail", bus.credit_o, 0);

        // Port 2 fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b1, FW'(16'hA001 + i), 1'b0);
            step();
        end
        idle();
        check("p2_count_full", cnt_of(2), 4);
        check("p2_full", bus.full_o[2], 1);
        check("p2_ovf_before", bus.ovf_o[2], 0);
        check("p2_head", q_of(2), 16'hA001);
        drive(2, 1'b1, 16'hA005, 1'b0);
        step();
        idle();
        check("p2_ovf_set", bus.ovf_o[2], 1);
        check("p2_count_after_drop", cnt_of(2), 4);
        for (int i = 0; i < 4; i++) begin
            expect_pop(2, FW'(16'hA001 + i));
            drive(2, 1'b0, '0, 1'b1);
            step();
        end
        idle();
        check("p2_last_credit", bus.credit_o, 5'b00100);
        step();
        check("p2_count_drained", cnt_of(2), 0);
        check("p2_en_drained", bus.en_o[2], 0);
        check("p2_ovf_sticky", bus.ovf_o[2], 1);
        check("p2_credits", credit_seen[2], 4);

        // Port 0 full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, FW'(16'hB001 + i), 1'b0);
            step();
        end
        idle();
        check("p0_full", bus.full_o[0], 1);
        expect_pop(0, 16'hB001);
        drive(0, 1'b1, 16'hB005, 1'b1);
        step();
        idle();
        check("p0_count_pushpop", cnt_of(0), 4);
        check("p0_full_pushpop", bus.full_o[0], 1);
        check("p0_ovf_pushpop", bus.ovf_o[0], 0);
        check("p0_head_pushpop", q_of(0), 16'hB002);
        check("p0_credit_pushpop", bus.credit_o[0], 1);
        for (int i = 0; i < 4; i++) begin
            expect_pop(0, FW'(16'hB002 + i));
            drive(0, 1'b0, '0, 1'b1);
            step();
        end
        idle();
        step();
        check("p0_count_drained", cnt_of(0), 0);
        check("p0_credits", credit_seen[0], 5);

        // Port 4 wrap-around at occupancy 1..2
        drive(4, 1'b1, 16'hD000, 1'b0);
        step();
        idle();
        nxt_push = 16'hD001;
        nxt_pop  = 16'hD000;
        for (int i = 0; i < 10; i++) begin
            ph = (i % 3 != 2);
            pp = (i % 3 != 0);
            if (pp) begin
                expect_pop(4, nxt_pop);
                nxt_pop = nxt_pop + 1'b1;
            end
            drive(4, ph, nxt_push, pp);
            if (ph) nxt_push = nxt_push + 1'b1;
            step();
            idle();
            check($sformatf("p4_count_%0d", i), cnt_of(4), exp_cnt[i]);
        end
        expect_pop(4, 16'hD006);
        expect_pop(4, 16'hD007);
        drive(4, 1'b0, '0, 1'b1);
        step();
        step();
        idle();
        step();
        check("p4_count_drained", cnt_of(4), 0);
        check("p4_credits", credit_seen[4], 8);

        // Independence: traffic on ports 1 and 3 only
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'b1, FW'(16'hE100 + i), 1'b0);
            drive(3, 1'b1, FW'(16'hF300 + i), 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            expect_pop(1, FW'(16'hE100 + i));
            drive(1, 1'b0, '0, 1'b1);
            drive(3, 1'b1, FW'(16'hF302 + i), 1'b0);
            step();
            check("indep_en_others", bus.en_o & 5'b10101, 0);
            check("indep_credit_only_p1", bus.credit_o & 5'b11101, 0);
            check("indep_count_others", {cnt_of(0), cnt_of(2), cnt_of(4)}, 0);
        end
        idle();
        step();
        check("indep_count_p1", cnt_of(1), 0);
        check("indep_count_p3", cnt_of(3), 4);
        check("indep_credits_p1", credit_seen[1], 2);
        check("indep_credits_p3", credit_seen[3], 0);

        // Reset mid-operation discards contents and ignores inputs
        rst = 1'b1;
        drive(3, 1'b1, 16'hF3FF, 1'b0);
        step();
        rst = 1'b0;
        idle();
        check("midrst_count", bus.count_o, 0);
        check("midrst_en", bus.en_o, 0);
        check("midrst_ovf", bus.ovf_o, 0);
        step();
        check("midrst_count_after", bus.count_o, 0);

        // Push with pop on empty port 0: bypass or one-cycle latency
        drive(0, 1'b1, 16'hC0DE, 1'b1);
`ifdef NOC_BUF_BYPASS_EN
        expect_pop(0, 16'hC0DE);
`endif
        #1;
`ifdef NOC_BUF_BYPASS_EN
        check("byp_en_same_cycle", bus.en_o[0], 1);
        check("byp_q_same_cycle", q_of(0), 16'hC0DE);
`else
        check("nobyp_en_same_cycle", bus.en_o[0], 0);
        check("nobyp_q_same_cycle", q_of(0), 0);
`endif
        step();
        idle();
        #1;
`ifdef NOC_BUF_BYPASS_EN
        check("byp_count_next", cnt_of(0), 0);
        check("byp_credit_next", bus.credit_o[0], 1);
        check("byp_en_next", bus.en_o[0], 0);
`else
        check("nobyp_count_next", cnt_of(0), 1);
        check("nobyp_credit_next", bus.credit_o[0], 0);
        check("nobyp_en_next", bus.en_o[0], 1);
        check("nobyp_q_next", q_of(0), 16'hC0DE);
        expect_pop(0, 16'hC0DE);
        drive(0, 1'b0, '0, 1'b1);
        step();
        idle();
        check("nobyp_credit_pop", bus.credit_o[0], 1);
`endif
        step();
        check("c0de_count_final", cnt_of(0), 0);
        check("p0_credits_total", credit_seen[0], 6);

        for (int p = 0; p < NP; p++) begin
            check($sformatf("exp_q_empty_p%0d", p), exp_q[p].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
